// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
//   XLEN                 : hart register / MMIO bus width
//   mem_write_control_t  : MMIO write request payload (enable, addr, value, width)
//   uart_tx_state_t      : shifter FSM state encoding
//   DEFAULT_*_ADDR       : default MMIO register addresses
package mmio_uart_tx_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic            enable;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    logic [1:0]      width;
  } mem_write_control_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_tx_state_t;

  localparam logic [XLEN-1:0] DEFAULT_TX_DATA_ADDR = 32'h0000_1000;
  localparam logic [XLEN-1:0] DEFAULT_STATUS_ADDR  = 32'h0000_1004;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MMIO port bundle between the hart (master) and a memory-mapped device (slave).
//   io_control        : write request, held high by the hart until completion
//   io_r_addr         : read address
//   io_r_data         : read data (combinational in the device)
//   io_write_complete : one-cycle write acknowledge
interface mmio_uart_tx_if;
  import mmio_uart_tx_pkg::*;

  mem_write_control_t io_control;
  logic [XLEN-1:0]    io_r_addr;
  logic [XLEN-1:0]    io_r_data;
  logic               io_write_complete;

  modport master (
    output io_control,
    output io_r_addr,
    input  io_r_data,
    input  io_write_complete
  );

  modport slave (
    input  io_control,
    input  io_r_addr,
    output io_r_data,
    output io_write_complete
  );

endinterface

// File: rtl/mmio_uart_tx_shifter.sv
// 8N1 serializer: FSM, baud counter and shift register.
//   clock, reset : clock, synchronous active-high reset
//   load         : a byte is waiting in the holding register
//   load_data    : that byte
//   ready_c      : the byte is taken at this edge when load is high
//   busy_c       : FSM is not idle
//   tx           : registered serial line, idle high
module uart_tx_shifter
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned clks_per_bit = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       ready_c,
  output logic       busy_c,
  output logic       tx
);

  localparam int unsigned CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clks_per_bit - 1);

  uart_tx_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_done_c;

  assign bit_done_c = (cnt == CNT_LAST);
  // The holding register is drained when idle, or at the last stop-bit cycle
  // so that back-to-back frames have no idle gap.
  assign ready_c    = (state == UART_IDLE) || ((state == UART_STOP) && bit_done_c);
  assign busy_c     = (state != UART_IDLE);

  // Frame sequencing; tx is driven for the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= UART_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          cnt <= '0;
          if (load) begin
            state <= UART_START;
            shift <= load_data;
            tx    <= 1'b0;
          end else begin
            tx <= 1'b1;
          end
        end
        UART_START: begin
          if (bit_done_c) begin
            state   <= UART_DATA;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        UART_DATA: begin
          if (bit_done_c) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= UART_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        UART_STOP: begin
          if (bit_done_c) begin
            cnt <= '0;
            if (load) begin
              state <= UART_START;
              shift <= load_data;
              tx    <= 1'b0;
            end else begin
              state <= UART_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= UART_IDLE;
          cnt   <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: one-byte holding register in front of an
// 8N1 shifter, plus a read-only status register.
//   clock, reset : clock, synchronous active-high reset
//   bus          : MMIO slave port (write request/ack, read addr/data)
//   tx           : UART serial line, idle high
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned     clks_per_bit = 868,
  parameter logic [XLEN-1:0] tx_data_addr = DEFAULT_TX_DATA_ADDR,
  parameter logic [XLEN-1:0] status_addr  = DEFAULT_STATUS_ADDR
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  logic [7:0] hold;
  logic       hold_full;
  logic       armed;
  logic       ready_c;
  logic       busy_c;
  logic       take_c;
  logic       is_data_c;
  logic       accept_c;
  logic       unused_ctrl_c;

  assign take_c    = hold_full && ready_c;
  assign is_data_c = (bus.io_control.addr == tx_data_addr);
  // A full hold only blocks data writes, and not when it drains this edge.
  assign accept_c  = bus.io_control.enable && armed &&
                     (!is_data_c || !hold_full || take_c);

  // Only the low byte is transmitted, whatever the access width.
  assign unused_ctrl_c = ^{bus.io_control.width, bus.io_control.value[XLEN-1:8]};

  // Holding register, re-arm tracking and write acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold                  <= '0;
      hold_full             <= 1'b0;
      armed                 <= 1'b1;
      bus.io_write_complete <= 1'b0;
    end else begin
      bus.io_write_complete <= accept_c;
      if (accept_c) begin
        armed <= 1'b0;
      end else if (!bus.io_control.enable) begin
        armed <= 1'b1;
      end
      if (accept_c && is_data_c) begin
        hold      <= bus.io_control.value[7:0];
        hold_full <= 1'b1;
      end else if (take_c) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign bus.io_r_data = (bus.io_r_addr == status_addr) ?
                         XLEN'({hold_full, busy_c}) : '0;

  uart_tx_shifter #(
    .clks_per_bit (clks_per_bit)
  ) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (hold_full),
    .load_data (hold),
    .ready_c   (ready_c),
    .busy_c    (busy_c),
    .tx        (tx)
  );

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (clks_per_bit = 4). A transaction-level
// reference model tracks the holding register and frame start times; the
// expected line level is derived arithmetically from the frame timeline.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam int unsigned CPB    = 4;
  localparam int          FRAME  = 10 * CPB;
  localparam logic [31:0] DATA_A = 32'h0000_1000;
  localparam logic [31:0] STAT_A = 32'h0000_1004;

  logic clock;
  logic reset;
  logic tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .clks_per_bit (CPB),
    .tx_data_addr (DATA_A),
    .status_addr  (STAT_A)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  int         edge_n    = 0;
  bit         m_hold_full = 1'b0;
  bit         m_armed   = 1'b1;
  logic [7:0] m_hold    = '0;
  bit         m_have    = 1'b0;
  int         m_start   = 0;
  logic [7:0] m_byte    = '0;
  bit         m_wc      = 1'b0;
  int         last_acc  = 0;

  // Bookkeeping
  int          n_vec = 0;
  int          n_err = 0;
  int          wc_count = 0;
  logic        tx_hist[$];
  logic        last_tx;
  logic [31:0] last_rdata;

  function automatic bit line_busy(int e);
    return m_have && (e < m_start + FRAME);
  endfunction

  function automatic logic exp_tx(int e);
    int k;
    if (!line_busy(e)) return 1'b1;
    k = (e - m_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic hist(int e);
    return tx_hist[e-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare all outputs on the falling edge.
  task automatic step();
    bit                 r;
    mem_write_control_t c;
    bit                 take, acc;
    logic [31:0]        er;
    r = reset;
    c = bus.io_control;
    @(posedge clock);
    edge_n++;
    if (r) begin
      m_hold_full = 1'b0;
      m_armed     = 1'b1;
      m_wc        = 1'b0;
      m_have      = 1'b0;
    end else begin
      take = m_hold_full && !line_busy(edge_n);
      acc  = c.enable && m_armed && (c.addr != DATA_A || !m_hold_full || take);
      if (take) begin
        m_have      = 1'b1;
        m_start     = edge_n;
        m_byte      = m_hold;
        m_hold_full = 1'b0;
      end
      if (acc && c.addr == DATA_A) begin
        m_hold      = c.value[7:0];
        m_hold_full = 1'b1;
      end
      m_wc = acc;
      if (acc) begin
        m_armed  = 1'b0;
        last_acc = edge_n;
      end else if (!c.enable) begin
        m_armed = 1'b1;
      end
    end
    @(negedge clock);
    er = (bus.io_r_addr == STAT_A) ? {30'b0, m_hold_full, line_busy(edge_n)} : 32'b0;
    check("tx", {31'b0, tx}, {31'b0, exp_tx(edge_n)});
    check("write_complete", {31'b0, bus.io_write_complete}, {31'b0, m_wc});
    check("r_data", bus.io_r_data, er);
    if (bus.io_write_complete === 1'b1) wc_count++;
    tx_hist.push_back(tx);
    last_tx    = tx;
    last_rdata = bus.io_r_data;
    bus.io_r_addr = ($urandom_range(0, 3) == 0) ? 32'($urandom) : STAT_A;
  endtask

  task automatic idle(input int n);
    bus.io_control = '0;
    repeat (n) step();
  endtask

  // Hart-style write: hold the request until acknowledged, optionally keep
  // enable high for extra cycles, then drop it for one cycle.
  task automatic mmio_write(input logic [31:0] a, input logic [31:0] v, input int extra);
    bit ok;
    ok = 1'b0;
    bus.io_control = '{enable: 1'b1, addr: a, value: v, width: 2'd2};
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_wc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $error("FAIL write_timeout addr %h: observed no completion expected one within 200 cycles", a);
    end
    repeat (extra) step();
    bus.io_control = '0;
    step();
  endtask

  task automatic drain();
    bus.io_control = '0;
    for (int i = 0; i < 400; i++) begin
      if (!m_hold_full && !line_busy(edge_n)) break;
      step();
    end
  endtask

  initial begin : stim
    logic [9:0] f55;
    int a1, a3, s, w0;
    f55 = {1'b1, 8'h55, 1'b0};

    // Reset state
    reset = 1'b1;
    bus.io_control = '0;
    bus.io_r_addr  = STAT_A;
    step();
    step();
    reset = 1'b0;
    bus.io_r_addr = STAT_A;
    step();
    check("reset_tx", {31'b0, last_tx}, 32'd1);
    check("reset_status", last_rdata, 32'h0);

    // Single byte from idle; only value[7:0] is sent
    mmio_write(DATA_A, 32'hFFFF_FF55, 0);
    a1 = last_acc;
    drain();
    idle(2);
    check("pre_frame_idle", {31'b0, hist(a1)}, 32'd1);
    for (int k = 0; k < FRAME; k++)
      check("frame_55", {31'b0, hist(a1 + 1 + k)}, {31'b0, f55[k/CPB]});
    check("post_frame_idle", {31'b0, hist(a1 + 1 + FRAME)}, 32'd1);

    // Three back-to-back writes: third stalls until hold drains, frames contiguous
    mmio_write(DATA_A, 32'h01, 0);
    a1 = last_acc;
    mmio_write(DATA_A, 32'h02, 0);
    mmio_write(DATA_A, 32'h03, 0);
    a3 = last_acc;
    check("third_accept_edge", 32'(a3), 32'(a1 + 1 + FRAME));
    drain();
    idle(2);
    check("f1_stop", {31'b0, hist(a1 + FRAME)}, 32'd1);
    check("f2_start", {31'b0, hist(a1 + 1 + FRAME)}, 32'd0);
    check("f2_stop", {31'b0, hist(a1 + 2 * FRAME)}, 32'd1);
    check("f3_start", {31'b0, hist(a1 + 1 + 2 * FRAME)}, 32'd0);

    // Enable held for 20 cycles: one completion
    w0 = wc_count;
    mmio_write(DATA_A, 32'h3C, 19);
    drain();
    idle(4);
    check("single_pulse", 32'(wc_count - w0), 32'd1);

    // Write to an unmapped address: acknowledged, nothing sent
    mmio_write(32'h0000_2000, 32'h77, 0);
    idle(20);
    bus.io_r_addr = STAT_A;
    step();
    check("other_addr_tx", {31'b0, last_tx}, 32'd1);
    check("other_addr_status", last_rdata, 32'h0);

    // Status during a frame with hold full, then after draining
    mmio_write(DATA_A, 32'h11, 0);
    mmio_write(DATA_A, 32'h22, 0);
    bus.io_r_addr = STAT_A;
    step();
    check("status_full_busy", last_rdata, 32'h3);
    drain();
    bus.io_r_addr = STAT_A;
    step();
    check("status_drained", last_rdata, 32'h0);

    // Reset during data bit 3, then a clean frame
    mmio_write(DATA_A, 32'h00, 0);
    s = last_acc + 1;
    for (int i = 0; i < 100 && edge_n < s + 17; i++) step();
    reset = 1'b1;
    bus.io_r_addr = STAT_A;
    step();
    reset = 1'b0;
    check("abort_tx", {31'b0, last_tx}, 32'd1);
    check("abort_status", last_rdata, 32'h0);
    idle(10);
    mmio_write(DATA_A, 32'hA5, 0);
    drain();
    idle(2);

    // Enable held through reset is accepted right after release
    bus.io_control = '{enable: 1'b1, addr: DATA_A, value: 32'h5A, width: 2'd0};
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("accept_after_reset", {31'b0, bus.io_write_complete}, 32'd1);
    bus.io_control = '0;
    drain();
    idle(2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 30; n++) begin
      idle($urandom_range(0, 50));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      if ($urandom_range(0, 4) == 0)
        mmio_write(32'($urandom), 32'($urandom), $urandom_range(0, 3));
      else
        mmio_write(DATA_A, 32'($urandom), $urandom_range(0, 3));
    end
    drain();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter clks_per_bit, default 868, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter tx_data_addr, default 32'h0000_1000, MMIO address of the transmit-data register.
REQ-003 SHALL have parameter status_addr, default 32'h0000_1004, MMIO address of the read-only status register.
REQ-004 clock  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 io_control  input  mem_write_control_t  MMIO write request (enable, addr, value, width), held level-high by the hart until completion.
REQ-007 io_r_addr  input  XLEN  MMIO read address.
REQ-008 io_r_data  output  XLEN  MMIO read data.
REQ-009 io_write_complete  output  1  one-cycle pulse acknowledging the current write request.
REQ-010 tx  output  1  UART serial line, 8N1, idle high.

Function
REQ-011 Holding register: one byte plus hold_full flag, between the MMIO port and the shifter.
REQ-012 Accept condition: io_control.enable && armed && (addr != tx_data_addr || !hold_full || shifter loads from hold in the same cycle).
REQ-013 On accept to tx_data_addr: store io_control.value[7:0] in hold, regardless of width; set hold_full.
REQ-014 On accept to any other address: discard data; state unchanged.
REQ-015 io_write_complete SHALL be high exactly in the cycle after accept, registered; low otherwise.
REQ-016 armed SHALL clear on accept and set again only after a cycle with io_control.enable low; one request produces exactly one completion.
REQ-017 Write to tx_data_addr with hold_full and no same-cycle load: stall, with no completion, until the hold empties.
REQ-018 Shifter FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE with hold_full at the edge -> START next cycle: load shift register from hold, clear hold_full, baud counter = 0.
REQ-020 START: tx=0 for clks_per_bit cycles -> DATA, bit index 0.
REQ-021 DATA: tx=shift[0], LSB first; each bit lasts clks_per_bit cycles; after bit 7 -> STOP.
REQ-022 STOP: tx=1 for clks_per_bit cycles; then -> START if hold_full (load as REQ-019, no idle gap), else -> IDLE.
REQ-023 tx SHALL be registered; IDLE -> tx=1; a frame is exactly 10*clks_per_bit cycles.
REQ-024 Latency: accept at edge N -> io_write_complete and hold_full high after N; tx low from edge N+1 when the shifter was IDLE.
REQ-025 Baud counter width = $clog2(clks_per_bit); wraps to 0 at clks_per_bit-1.
REQ-026 io_r_data, combinational: at status_addr = {30'b0, hold_full, state!=IDLE}; all other addresses = 0.
REQ-027 Same-cycle shifter load from hold and accept into hold is legal; the new byte is retained.

Reset
REQ-028 Reset asserted in any state, including mid-frame, SHALL on the next edge force: state IDLE, tx=1, hold_full=0, armed=1, io_write_complete=0, counters 0.
REQ-029 An aborted frame SHALL NOT resume after reset.
REQ-030 An enable held through reset SHALL be accepted on the first cycle after reset deasserts.

Structure
REQ-031 Shared package SHALL hold uart_tx_state_t and the default MMIO address constants; mem_write_control_t and XLEN come from the existing shared package.
REQ-032 Single sub-module uart_tx_shifter (FSM, baud counter, shift register), with a load/ready handshake to the holding register in mmio_uart_tx.

Verification (bench clks_per_bit=4)
REQ-033 Write 0x55 to tx_data_addr while idle -> completion 1 cycle later; tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; total 40 cycles.
REQ-034 Three back-to-back writes 0x01, 0x02, 0x03 -> third completion withheld until the first frame's load frees hold; frames contiguous, with no idle cycles between stop and start bits.
REQ-035 Enable held high for 20 cycles with one request -> exactly one io_write_complete pulse and one frame.
REQ-036 Write to 0x0000_2000 -> completion after 1 cycle, tx stays high, status reads 0.
REQ-037 Reset asserted during DATA bit 3 -> tx=1 next cycle; status 0; next write 0xA5 transmits a clean frame.
REQ-038 Read status_addr during a frame with hold_full -> 32'h3; after both drain -> 32'h0.
